// File: rtl/cyclops_pkg.sv
// Shared definitions for the cyclops display pipeline (rect_filler, VGA
// scan-out, top level).
//   pixel_t      : packed 24-bit RGB pixel, 8 bits per channel
//   H_ACTIVE     : default visible width in pixels
//   V_ACTIVE     : default visible height in lines
//   FB_ADDR_W    : frame-buffer address width
//   fill_state_t : rect_filler FSM encoding, visible on its debug port
//   fb_addr()    : maps an (x, y) pixel position to a frame-buffer address
package cyclops_pkg;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int FB_ADDR_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

  // Only y[8:0] is used. Every caller guarantees y < 480, so the top bit is
  // always zero.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [9:0] x,
                                                   input logic [9:0] y);
    return {y[8:0], x};
  endfunction

endpackage

// File: rtl/rect_filler.sv
// rect_filler: accepts axis-aligned rectangle fill commands, clips them to the
// visible area, and writes one pixel per granted cycle into the frame buffer.
//
// Handshakes:
//   cmd  : a command transfers on a rising clock edge where cmd_valid and
//          cmd_ready are both high. cmd_ready is high only in IDLE. While it
//          is low, the cmd_* inputs are ignored.
//   wr   : a pixel write completes on a rising clock edge where wr_en and
//          wr_ready are both high. While wr_en is high and wr_ready is low,
//          wr_addr and wr_data hold their values.
//
// Ports:
//   clock, reset            : clock; asynchronous active-low reset
//   cmd_valid / cmd_ready   : command handshake
//   cmd_x0/y0, cmd_x1/y1    : inclusive corners (10-bit unsigned)
//   cmd_color               : fill colour
//   wr_en / wr_ready        : pixel write handshake
//   wr_addr, wr_data        : {y[8:0], x[9:0]} address and pixel value
//   busy                    : high in FILL and DONE
//   done                    : one-cycle pulse when a fill completes
//   err                     : one-cycle pulse when a command is rejected
//   dbg_state               : current FSM state
module rect_filler
  import cyclops_pkg::*;
#(
  parameter int H_ACTIVE = cyclops_pkg::H_ACTIVE,
  parameter int V_ACTIVE = cyclops_pkg::V_ACTIVE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [9:0]           cmd_x0,
  input  logic [9:0]           cmd_y0,
  input  logic [9:0]           cmd_x1,
  input  logic [9:0]           cmd_y1,
  input  pixel_t               cmd_color,
  output logic                 wr_en,
  input  logic                 wr_ready,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output pixel_t               wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output fill_state_t          dbg_state
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  fill_state_t state;
  logic [9:0]  x, y;
  logic [9:0]  x_start, x_end, y_end;

  // Clip and reject. The checks against X_LAST and Y_LAST are the ">= active
  // size" tests. They also catch a start corner that lies off-screen even when
  // the end corner is smaller.
  logic [9:0] clip_xe, clip_ye;
  logic       cmd_reject;

  always_comb begin
    clip_xe    = (cmd_x1 > X_LAST) ? X_LAST : cmd_x1;
    clip_ye    = (cmd_y1 > Y_LAST) ? Y_LAST : cmd_y1;
    cmd_reject = (cmd_x0 > clip_xe) || (cmd_y0 > clip_ye) ||
                 (cmd_x0 > X_LAST)  || (cmd_y0 > Y_LAST);
  end

  assign cmd_ready = (state == ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      x       <= '0;
      y       <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_reject) begin
              err <= 1'b1;
            end else begin
              x       <= cmd_x0;
              y       <= cmd_y0;
              x_start <= cmd_x0;
              x_end   <= clip_xe;
              y_end   <= clip_ye;
              wr_en   <= 1'b1;
              wr_addr <= fb_addr(cmd_x0, cmd_y0);
              wr_data <= cmd_color;
              busy    <= 1'b1;
              state   <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          // The raster position moves only on a granted write, so a stall
          // leaves the address and data unchanged.
          if (wr_en && wr_ready) begin
            if (x == x_end) begin
              if (y == y_end) begin
                wr_en <= 1'b0;
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                x       <= x_start;
                y       <= y + 10'd1;
                wr_addr <= fb_addr(x_start, y + 10'd1);
              end
            end else begin
              x       <= x + 10'd1;
              wr_addr <= fb_addr(x + 10'd1, y);
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_filler.sv
module tb_rect_filler;
  import cyclops_pkg::*;

  // ---------------- clock / reset ----------------
  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [9:0]           cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  pixel_t               cmd_color = '0;
  logic                 wr_en;
  logic                 wr_ready = 1'b1;
  logic [FB_ADDR_W-1:0] wr_addr;
  pixel_t               wr_data;
  logic                 busy, done, err;
  fill_state_t          dbg_state;

  always #5 clock = ~clock;

  rect_filler dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Expected addresses, computed as y*1024 + x over the clipped rectangle.
  logic [FB_ADDR_W-1:0] exp_q[$];
  int                   exp_err;

  task automatic model_cmd(input int x0, input int y0, input int x1, input int y1);
    int xe, ye;
    xe = (x1 < H_ACTIVE) ? x1 : H_ACTIVE - 1;
    ye = (y1 < V_ACTIVE) ? y1 : V_ACTIVE - 1;
    exp_q.delete();
    exp_err = (x0 > xe || y0 > ye || x0 >= H_ACTIVE || y0 >= V_ACTIVE) ? 1 : 0;
    if (exp_err == 0)
      for (int yy = y0; yy <= ye; yy++)
        for (int xx = x0; xx <= xe; xx++)
          exp_q.push_back(FB_ADDR_W'(yy * 1024 + xx));
  endtask

  // ---------------- driver / recorder ----------------
  logic [FB_ADDR_W-1:0] g_addr[$];
  pixel_t               g_data[$];
  int                   g_cyc[$];
  int en_cycles, done_cnt, err_cnt, done_cyc, err_cyc, ready_cyc, ready_low;
  int both_cnt, stall_bad, busy_ready_bad, timed_out;
  int rdy_mode;   // 0: always granted, 1: rdy_pat then granted, 2: random
  int rdy_pat[$];
  bit junk_mode;  // drive random commands while the fill is running

  // Cycle k is counted from the acceptance cycle N, so k=1 means N+1.
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input pixel_t color, input int budget);
    int end_k;
    logic                 prev_stall;
    logic [FB_ADDR_W-1:0] prev_addr;
    pixel_t               prev_data;
    g_addr.delete(); g_data.delete(); g_cyc.delete();
    en_cycles = 0; done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
    ready_cyc = -1; ready_low = 0; both_cnt = 0; stall_bad = 0;
    busy_ready_bad = 0; timed_out = 1; end_k = -1;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    @(negedge clock);
    cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
    cmd_color = color; cmd_valid = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      if (rdy_mode == 0) wr_ready = 1'b1;
      else if (rdy_mode == 1) wr_ready = (k - 1 < rdy_pat.size()) ? (rdy_pat[k-1] != 0) : 1'b1;
      else wr_ready = ($urandom_range(0, 3) != 0);
      if (wr_en) en_cycles++;
      if (wr_en && prev_stall && (wr_addr !== prev_addr || wr_data !== prev_data)) stall_bad++;
      if (wr_en && wr_ready) begin
        g_addr.push_back(wr_addr); g_data.push_back(wr_data); g_cyc.push_back(k);
      end
      prev_stall = wr_en && !wr_ready; prev_addr = wr_addr; prev_data = wr_data;
      if (done) begin done_cnt++; done_cyc = k; end
      if (err) begin err_cnt++; err_cyc = k; end
      if (done && err) both_cnt++;
      if (cmd_ready && ready_cyc < 0) ready_cyc = k;
      if (!cmd_ready) ready_low++;
      if (wr_en && cmd_ready) busy_ready_bad++;
      if (junk_mode && wr_en) begin
        cmd_valid = 1'($urandom);
        cmd_x0 = 10'($urandom); cmd_y0 = 10'($urandom);
        cmd_x1 = 10'($urandom); cmd_y1 = 10'($urandom);
        cmd_color = pixel_t'($urandom);
      end
      if ((done || err) && end_k < 0) end_k = k + 2;
      if (k == end_k) begin timed_out = 0; break; end
    end
    cmd_valid = 1'b0;
    wr_ready  = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %0h want 1", cmd_ready); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %0h want 0", wr_en); end
    total++; if (wr_addr !== '0) begin bad++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    total++; if (wr_data !== '0) begin bad++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    reset = 1'b1;
    @(negedge clock);
    total++; if (cmd_ready !== 1'b1 || wr_en !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got ready=%0h en=%0h want 1/0", cmd_ready, wr_en); end
  endtask

  task automatic test_basic();
    pixel_t c;
    c = 24'hFF0000;
    rdy_mode = 0; junk_mode = 0;
    model_cmd(10, 20, 12, 21);
    run_cmd(10, 20, 12, 21, c, 50);
    total++; if (timed_out != 0) begin bad++; $display("FAIL basic_timeout: got %0d want 0", timed_out); end
    total++; if (g_addr.size() != exp_q.size()) begin bad++; $display("FAIL basic_count: got %0d want %0d", g_addr.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < g_addr.size(); i++) begin
      total++; if (g_addr[i] !== exp_q[i] || g_data[i] !== c || g_cyc[i] != i + 1) begin
        bad++; $display("FAIL basic_write%0d: got addr=%0h data=%0h cyc=%0d want addr=%0h data=%0h cyc=%0d",
                        i, g_addr[i], g_data[i], g_cyc[i], exp_q[i], c, i + 1);
      end
    end
    total++; if (done_cyc != 7 || done_cnt != 1) begin bad++; $display("FAIL basic_done: got cyc=%0d cnt=%0d want 7/1", done_cyc, done_cnt); end
    total++; if (ready_cyc != 8) begin bad++; $display("FAIL basic_ready_again: got %0d want 8", ready_cyc); end
    total++; if (err_cnt != 0) begin bad++; $display("FAIL basic_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_clip();
    pixel_t c;
    c = 24'h00A5C3;
    rdy_mode = 0; junk_mode = 0;
    model_cmd(636, 478, 700, 600);
    run_cmd(636, 478, 700, 600, c, 50);
    total++; if (g_addr.size() != 8 || timed_out != 0) begin bad++; $display("FAIL clip_count: got %0d want 8", g_addr.size()); end
    for (int i = 0; i < exp_q.size() && i < g_addr.size(); i++) begin
      total++; if (g_addr[i] !== exp_q[i] || g_data[i] !== c) begin
        bad++; $display("FAIL clip_write%0d: got %0h/%0h want %0h/%0h", i, g_addr[i], g_data[i], exp_q[i], c);
      end
    end
    if (g_addr.size() > 0) begin
      total++; if (g_addr[g_addr.size()-1] !== {9'd479, 10'd639}) begin bad++; $display("FAIL clip_last: got %0h want %0h", g_addr[g_addr.size()-1], {9'd479, 10'd639}); end
    end
    total++; if (done_cyc != 9) begin bad++; $display("FAIL clip_done: got %0d want 9", done_cyc); end
  endtask

  task automatic test_reject();
    int cmds[2][4];
    cmds[0] = '{700, 0, 710, 5};
    cmds[1] = '{50, 50, 40, 60};
    rdy_mode = 0; junk_mode = 0;
    for (int n = 0; n < 2; n++) begin
      model_cmd(cmds[n][0], cmds[n][1], cmds[n][2], cmds[n][3]);
      run_cmd(cmds[n][0], cmds[n][1], cmds[n][2], cmds[n][3], 24'h123456, 20);
      total++; if (err_cnt != exp_err || err_cyc != 1) begin bad++; $display("FAIL reject%0d_err: got cnt=%0d cyc=%0d want %0d/1", n, err_cnt, err_cyc, exp_err); end
      total++; if (en_cycles != 0 || done_cnt != 0) begin bad++; $display("FAIL reject%0d_writes: got en=%0d done=%0d want 0/0", n, en_cycles, done_cnt); end
      total++; if (ready_low != 0) begin bad++; $display("FAIL reject%0d_ready: got low_cycles=%0d want 0", n, ready_low); end
    end
  endtask

  task automatic test_backpressure();
    int exp_cyc[$];
    int left;
    pixel_t c;
    c = 24'h3C3C3C;
    rdy_mode = 1; junk_mode = 0;
    rdy_pat = '{1, 0, 0, 1, 0, 1, 1};
    model_cmd(0, 0, 3, 0);
    // grants land on the cycles where the pattern is high until all writes are done
    left = exp_q.size();
    for (int k = 1; left > 0 && k < 40; k++)
      if (k - 1 >= rdy_pat.size() || rdy_pat[k-1] != 0) begin exp_cyc.push_back(k); left--; end
    run_cmd(0, 0, 3, 0, c, 40);
    total++; if (g_addr.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", g_addr.size()); end
    for (int i = 0; i < exp_q.size() && i < g_addr.size(); i++) begin
      total++; if (g_addr[i] !== exp_q[i] || g_cyc[i] != exp_cyc[i]) begin
        bad++; $display("FAIL bp_write%0d: got addr=%0h cyc=%0d want addr=%0h cyc=%0d", i, g_addr[i], g_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stall_bad); end
    total++; if (done_cyc != exp_cyc[exp_cyc.size()-1] + 1) begin bad++; $display("FAIL bp_done: got %0d want %0d", done_cyc, exp_cyc[exp_cyc.size()-1] + 1); end
    rdy_mode = 0;
  endtask

  task automatic test_busy_ignore();
    pixel_t c;
    c = 24'h00FF00;
    rdy_mode = 0; junk_mode = 1;
    model_cmd(100, 200, 104, 202);
    run_cmd(100, 200, 104, 202, c, 60);
    junk_mode = 0;
    total++; if (g_addr.size() != exp_q.size() || timed_out != 0) begin bad++; $display("FAIL busy_count: got %0d want %0d", g_addr.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < g_addr.size(); i++) begin
      total++; if (g_addr[i] !== exp_q[i] || g_data[i] !== c) begin
        bad++; $display("FAIL busy_write%0d: got %0h/%0h want %0h/%0h", i, g_addr[i], g_data[i], exp_q[i], c);
      end
    end
    total++; if (busy_ready_bad != 0) begin bad++; $display("FAIL busy_cmd_ready: got %0d ready cycles want 0", busy_ready_bad); end
    total++; if (done_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL busy_done: got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid_fill();
    int grants;
    logic [FB_ADDR_W-1:0] last;
    rdy_mode = 0; wr_ready = 1'b1;
    @(negedge clock);
    cmd_x0 = 10'd0; cmd_y0 = 10'd0; cmd_x1 = 10'd639; cmd_y1 = 10'd479;
    cmd_color = 24'hABCDEF; cmd_valid = 1'b1;
    grants = 0; last = '0;
    for (int k = 1; k <= 200 && grants < 100; k++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      if (wr_en && wr_ready) begin grants++; last = wr_addr; end
    end
    total++; if (grants != 100 || last !== FB_ADDR_W'(99)) begin bad++; $display("FAIL mid_progress: got grants=%0d last=%0h want 100/63", grants, last); end
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    total++; if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL mid_async_clear: got en=%0h busy=%0h done=%0h err=%0h want 0", wr_en, busy, done, err);
    end
    total++; if (wr_addr !== '0 || wr_data !== '0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_async_outputs: got addr=%0h data=%0h ready=%0h want 0/0/1", wr_addr, wr_data, cmd_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_held_wr_en%0d: got %0h want 0", k, wr_en); end
    end
    reset = 1'b1;
    @(negedge clock);
    total++; if (dbg_state !== ST_IDLE || cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_release: got state=%0d ready=%0h want %0d/1", dbg_state, cmd_ready, ST_IDLE); end
    model_cmd(5, 5, 5, 5);
    run_cmd(5, 5, 5, 5, 24'h777777, 20);
    total++; if (g_addr.size() != 1) begin bad++; $display("FAIL one_count: got %0d want 1", g_addr.size()); end
    if (g_addr.size() > 0) begin
      total++; if (g_addr[0] !== {9'd5, 10'd5} || g_addr[0] !== exp_q[0]) begin bad++; $display("FAIL one_addr: got %0h want %0h", g_addr[0], {9'd5, 10'd5}); end
    end
    total++; if (done_cyc != 2) begin bad++; $display("FAIL one_done: got %0d want 2", done_cyc); end
  endtask

  task automatic test_random();
    int x0, y0, x1, y1;
    pixel_t c;
    rdy_mode = 2; junk_mode = 0;
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 2))
        0: x0 = $urandom_range(0, 8);
        1: x0 = $urandom_range(630, 645);
        default: x0 = $urandom_range(0, 700);
      endcase
      case ($urandom_range(0, 2))
        0: y0 = $urandom_range(0, 8);
        1: y0 = $urandom_range(470, 485);
        default: y0 = $urandom_range(0, 500);
      endcase
      x1 = x0 + $urandom_range(0, 5);
      y1 = y0 + $urandom_range(0, 4);
      if ($urandom_range(0, 5) == 0 && x0 > 0) x1 = x0 - 1;
      c = pixel_t'($urandom);
      model_cmd(x0, y0, x1, y1);
      run_cmd(x0, y0, x1, y1, c, 600);
      total++; if (timed_out != 0) begin bad++; $display("FAIL rnd%0d_timeout: got %0d want 0", n, timed_out); end
      total++; if (g_addr.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d (%0d,%0d,%0d,%0d)", n, g_addr.size(), exp_q.size(), x0, y0, x1, y1); end
      for (int i = 0; i < exp_q.size() && i < g_addr.size(); i++) begin
        total++; if (g_addr[i] !== exp_q[i] || g_data[i] !== c) begin
          bad++; $display("FAIL rnd%0d_write%0d: got %0h/%0h want %0h/%0h", n, i, g_addr[i], g_data[i], exp_q[i], c);
        end
      end
      total++; if (err_cnt != exp_err || done_cnt != 1 - exp_err || both_cnt != 0) begin
        bad++; $display("FAIL rnd%0d_pulses: got err=%0d done=%0d both=%0d want %0d/%0d/0", n, err_cnt, done_cnt, both_cnt, exp_err, 1 - exp_err);
      end
      total++; if (stall_bad != 0) begin bad++; $display("FAIL rnd%0d_stable: got %0d want 0", n, stall_bad); end
      if (exp_err == 0 && g_cyc.size() > 0) begin
        total++; if (done_cyc != g_cyc[g_cyc.size()-1] + 1) begin bad++; $display("FAIL rnd%0d_done_cyc: got %0d want %0d", n, done_cyc, g_cyc[g_cyc.size()-1] + 1); end
      end
    end
    rdy_mode = 0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rdy_mode = 0;
    junk_mode = 0;
    test_reset();
    test_basic();
    test_clip();
    test_reject();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
